// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared sequencer state encoding and debug counter width
package reset_seq_pkg;
    typedef enum logic [1:0] {HOLD, RELEASE, RUN} seq_state_t;
    localparam int LLC_W = 8;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for one asynchronous level, cleared to 0
module bit_synchronizer #(
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    // shift the asynchronous level through the flop chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ff <= '0;
        else          ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: waits for stable lock, then releases resets stage by stage
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_LOCK    = 2,
    parameter int NUM_STAGES  = 3,
    parameter int SYNC_STAGES = 4,
    parameter int STAGE_DELAY = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_LOCK-1:0]   locked,
    input  logic                  force_reset,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [LLC_W-1:0]      lock_loss_count
);
    localparam int CW = STAGE_DELAY > 1 ? $clog2(STAGE_DELAY) : 1;
    localparam int IW = $clog2(NUM_STAGES + 1);

    logic [NUM_LOCK-1:0]   lock_sync;
    logic                  lock_ok, ok, last_cnt;
    seq_state_t            state_q, state_nx;
    logic [CW-1:0]         cnt_q, cnt_nx;
    logic [IW-1:0]         idx_q, idx_nx;
    logic [NUM_STAGES-1:0] rst_nx;
    logic                  ready_nx;
    logic [LLC_W-1:0]      llc_nx;

    genvar i;
    generate
        for (i = 0; i < NUM_LOCK; i++) begin : g_sync
            bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
                .clk    (clk),
                .reset_n(reset_n),
                .d      (locked[i]),
                .q      (lock_sync[i])
            );
        end
    endgenerate

    assign lock_ok  = &lock_sync;
    assign ok       = lock_ok & ~force_reset;
    assign last_cnt = cnt_q == CW'(STAGE_DELAY - 1);

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= HOLD;
            cnt_q           <= '0;
            idx_q           <= '0;
            rst_out         <= '1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            state_q         <= state_nx;
            cnt_q           <= cnt_nx;
            idx_q           <= idx_nx;
            rst_out         <= rst_nx;
            ready           <= ready_nx;
            lock_loss_count <= llc_nx;
        end
    end

    // sequencing: count stable lock in HOLD, step stages in RELEASE, abort to HOLD on loss
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        idx_nx   = idx_q;
        rst_nx   = rst_out;
        ready_nx = ready;
        llc_nx   = lock_loss_count;
        case (state_q)
            HOLD: begin
                if (!ok) begin
                    cnt_nx = '0;
                end else if (last_cnt) begin
                    rst_nx   = rst_out & ~NUM_STAGES'(1);
                    cnt_nx   = '0;
                    idx_nx   = IW'(1);
                    state_nx = NUM_STAGES == 1 ? RUN : RELEASE;
                    ready_nx = NUM_STAGES == 1;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end
            RELEASE, RUN: begin
                if (!ok) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    rst_nx   = '1;
                    ready_nx = 1'b0;
                    llc_nx   = (!lock_ok && lock_loss_count != '1) ? lock_loss_count + LLC_W'(1) : lock_loss_count;
                end else if (state_q == RELEASE) begin
                    if (last_cnt) begin
                        rst_nx = rst_out & ~(NUM_STAGES'(1) << idx_q);
                        cnt_nx = '0;
                        idx_nx = idx_q + IW'(1);
                        if (idx_q == IW'(NUM_STAGES - 1)) begin
                            state_nx = RUN;
                            ready_nx = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt_q + CW'(1);
                    end
                end
            end
            default: state_nx = HOLD;
        endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks against a stable-lock-run-length model
module tb_reset_sequencer;
    localparam int NL = 2;
    localparam int NS = 3;
    localparam int SS = 4;
    localparam int SD = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NL-1:0] locked = '0;
    logic          force_reset = 1'b0;
    logic [NS-1:0] rst_out;
    logic          ready;
    logic [7:0]    lock_loss_count;

    int errors = 0;
    int checks = 0;

    int          n_ok;
    int          m_llc;
    logic [SS-1:0] hist;

    reset_sequencer #(
        .NUM_LOCK(NL), .NUM_STAGES(NS), .SYNC_STAGES(SS), .STAGE_DELAY(SD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .locked         (locked),
        .force_reset    (force_reset),
        .rst_out        (rst_out),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    // stages released = whole delay periods of uninterrupted good lock, capped
    function automatic int released(input int n);
        return (n / SD < NS) ? n / SD : NS;
    endfunction

    function automatic logic [NS-1:0] mask(input int r);
        logic [31:0] v;
        v = ~((32'd1 << r) - 32'd1);
        return v[NS-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // model: lock seen SS edges late; any bad cycle zeroes the run length
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_ok  = 0;
            m_llc = 0;
            hist  = '0;
        end else begin : upd
            logic lo;
            lo   = hist[SS-1];
            hist = {hist[SS-2:0], &locked};
            if (lo && !force_reset) begin
                if (n_ok < NS * SD) n_ok = n_ok + 1;
            end else begin
                if (!lo && released(n_ok) >= 1 && m_llc < 255) m_llc = m_llc + 1;
                n_ok = 0;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        check("m_rst_out", 32'(rst_out), 32'(mask(released(n_ok))));
        check("m_ready", 32'(ready), 32'(released(n_ok) == NS));
        check("m_llc", 32'(lock_loss_count), m_llc);
    end

    initial begin
        tick(3);
        check("reset_rst", 32'(rst_out), 32'h7);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_llc", 32'(lock_loss_count), 32'h0);
        reset_n = 1'b1;

        locked = 2'b11;
        tick(19); check("s1_e19", 32'(rst_out), 32'h7);
        tick(1);  check("s1_e20", 32'(rst_out), 32'h6);
        tick(15); check("s1_e35", 32'(rst_out), 32'h6);
        tick(1);  check("s1_e36", 32'(rst_out), 32'h4);
        tick(15); check("s1_e51_ready", 32'(ready), 32'h0);
        tick(1);  check("s1_e52", 32'(rst_out), 32'h0);
        check("s1_ready", 32'(ready), 32'h1);
        check("s1_llc", 32'(lock_loss_count), 32'h0);

        locked = 2'b01;
        tick(3);
        locked = 2'b11;
        tick(1); check("s3_e4", 32'(rst_out), 32'h0);
        tick(1); check("s3_e5", 32'(rst_out), 32'h7);
        check("s3_ready", 32'(ready), 32'h0);
        check("s3_llc", 32'(lock_loss_count), 32'h1);
        tick(49); check("s3_reseq_pre", 32'(ready), 32'h0);
        tick(1);  check("s3_reseq", 32'(ready), 32'h1);

        locked = 2'b01;
        tick(200);
        check("s2_rst", 32'(rst_out), 32'h7);
        check("s2_ready", 32'(ready), 32'h0);
        check("s2_llc", 32'(lock_loss_count), 32'h2);

        locked = 2'b11;
        tick(25); check("s4_pre", 32'(rst_out), 32'h6);
        force_reset = 1'b1;
        tick(1); check("s4_abort", 32'(rst_out), 32'h7);
        check("s4_llc", 32'(lock_loss_count), 32'h2);
        force_reset = 1'b0;
        tick(15); check("s4_e15", 32'(rst_out), 32'h7);
        tick(1);  check("s4_e16", 32'(rst_out), 32'h6);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) locked = NL'($urandom_range(0, 3));
            else if (locked != 2'b11 && $urandom_range(0, 19) == 0) locked = 2'b11;
            force_reset = $urandom_range(0, 99) == 0;
            tick(1);
        end
        force_reset = 1'b0;

        for (int a = 0; a < 300; a++) begin
            locked = 2'b11;
            tick(SS + SD + 1 + $urandom_range(0, 40));
            locked = NL'($urandom_range(0, 2));
            tick(SS + 2);
        end
        check("s5_sat", 32'(lock_loss_count), 32'd255);

        locked = 2'b11;
        tick(40);
        check("s5_mid", 32'(rst_out), 32'h4);
        #2 reset_n = 1'b0;
        #1;
        check("s5_async_rst", 32'(rst_out), 32'h7);
        check("s5_async_ready", 32'(ready), 32'h0);
        check("s5_async_llc", 32'(lock_loss_count), 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(52);
        check("s5_reseq", 32'(ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
